// File: rtl/pam_mux_arbiter.sv
// Round-robin burst arbiter that drives the select of a shared PAM mux.
// Optional LOCK input (burst-limit hold) is enabled by defining PAM_ARB_LOCK_EN.
module pam_mux_arbiter #(
    parameter int Width    = 8,
    parameter int Depth    = 8,
    parameter int MaxBurst = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
`ifdef PAM_ARB_LOCK_EN
    input  logic                     LOCK,
`endif
    input  logic [Depth-1:0]         REQ,
    input  logic                     READY_IN,
    output logic [$clog2(Depth)-1:0] SEL,
    output logic [Depth-1:0]         GNT,
    output logic                     VALID_OUT,
    output logic                     BUSY
);

    localparam int SW = $clog2(Depth);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Width only documents the data path this arbiter steers; reject illegal sizing early.
    if (Width < 1 || Depth < 2 || Depth > 64 || MaxBurst < 1 || MaxBurst > 255) begin : g_param_check
        $error("pam_mux_arbiter: illegal parameter value");
    end

    state_t          r_state;
    state_t          w_next_state;
    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   r_ptr;
    logic [Depth-1:0] r_gnt;
    logic [7:0]      r_beat_cnt;

    logic [SW-1:0]   w_winner;
    logic [SW-1:0]   w_sel_inc;
    logic            w_req_sel;
    logic            w_xfer;
    logic            w_at_limit;
    logic            w_lock;
    logic            w_release;

`ifdef PAM_ARB_LOCK_EN
    assign w_lock = LOCK;
`else
    assign w_lock = 1'b0;
`endif

    assign w_req_sel  = REQ[r_sel];
    assign w_xfer     = (r_state == ST_GRANT) && w_req_sel && READY_IN;
    assign w_at_limit = (r_beat_cnt == 8'(MaxBurst - 1));
    assign w_release  = (r_state == ST_GRANT) &&
                        (!w_req_sel || (w_xfer && w_at_limit && !w_lock));
    assign w_sel_inc  = (r_sel == SW'(Depth - 1)) ? '0 : r_sel + 1'b1;

    // Round-robin scan: first asserted request at or above the pointer, wrapping to 0.
    always_comb begin
        logic [SW-1:0] idx;
        logic          hit;
        w_winner = r_ptr;
        idx      = r_ptr;
        hit      = 1'b0;
        for (int k = 0; k < Depth; k++) begin
            if (!hit && REQ[idx]) begin
                w_winner = idx;
                hit      = 1'b1;
            end
            idx = (idx == SW'(Depth - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (|REQ)     w_next_state = ST_GRANT;
            ST_GRANT: if (w_release) w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sel      <= '0;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (|REQ) begin
                r_sel      <= w_winner;
                r_gnt      <= Depth'(1) << w_winner;
                r_beat_cnt <= '0;
            end
        end else if (w_release) begin
            r_ptr <= w_sel_inc;
            r_gnt <= '0;
        end else if (w_xfer) begin
            // Only reached at the limit when LOCK holds the grant: start a new burst window.
            r_beat_cnt <= w_at_limit ? 8'd0 : r_beat_cnt + 8'd1;
        end
    end

    always_comb begin
        VALID_OUT = 1'b0;
        BUSY      = 1'b0;
        if (r_state == ST_GRANT) begin
            VALID_OUT = w_req_sel;
            BUSY      = 1'b1;
        end
    end

    assign SEL = r_sel;
    assign GNT = r_gnt;

endmodule

// File: doc/pam_mux_arbiter.md
PAM_MUX_ARBITER -- requirements
Module: pam_mux_arbiter

Interface
REQ-001 SHALL have parameter Width, default 8: data width of the shared PAM mux path; used only for documentation and consistency with the mux it drives.
REQ-002 SHALL have parameter Depth, default 8: number of requesters and mux inputs; legal range 2..64; non-power-of-two values legal.
REQ-003 SHALL have parameter MaxBurst, default 4: maximum beats per grant; legal range 1..255.
REQ-004 SHALL have port CLK, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port REQ, input, Depth bits: REQ[i]=1 means requester i has a beat pending on mux input i.
REQ-007 SHALL have port READY_IN, input, 1 bit: downstream accepts the beat this cycle.
REQ-008 SHALL have port SEL, output, $clog2(Depth) bits: mux select, registered.
REQ-009 SHALL have port GNT, output, Depth bits: one-hot grant, registered; all-zero when no grant.
REQ-010 SHALL have port VALID_OUT, output, 1 bit: beat on mux output is valid.
REQ-011 SHALL have port BUSY, output, 1 bit: 1 while in state GRANT.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-013 In IDLE with REQ nonzero, SHALL select the first asserted REQ index scanning upward from pointer PTR, wrapping Depth-1 -> 0.
REQ-014 On that selection, SHALL load SEL with the winner, set GNT one-hot, clear BEAT_CNT, and enter GRANT; GNT SHALL be visible one cycle after REQ is sampled.
REQ-015 In IDLE with REQ zero, SHALL remain in IDLE; SEL SHALL hold its last value and GNT SHALL be zero.
REQ-016 In GRANT, VALID_OUT SHALL equal REQ[SEL], combinationally; VALID_OUT SHALL be 0 in IDLE.
REQ-017 A beat transfers on a cycle with VALID_OUT=1 and READY_IN=1; each transfer SHALL increment BEAT_CNT.
REQ-018 SHALL release the grant when REQ[SEL]=0 in GRANT, or on a transfer with BEAT_CNT=MaxBurst-1.
REQ-019 On release, SHALL set PTR to SEL+1 modulo Depth, clear GNT, and return to IDLE for exactly one cycle before the next grant.
REQ-020 READY_IN=1 with VALID_OUT=0 SHALL NOT count a beat; READY_IN low SHALL stall without releasing.
REQ-021 Changes of REQ bits other than REQ[SEL] during GRANT SHALL have no effect until the next IDLE.

Reset
REQ-022 On RST=1, SHALL asynchronously force: state IDLE, SEL=0, GNT=0, PTR=0, BEAT_CNT=0, BUSY=0; VALID_OUT SHALL be 0.
REQ-023 RST asserted mid-grant SHALL abort the burst with no further beat counted; after deassertion, arbitration SHALL restart from PTR=0.

Configuration
REQ-024 Macro PAM_ARB_LOCK_EN SHALL, when defined, add input port LOCK, 1 bit.
REQ-025 With PAM_ARB_LOCK_EN defined and LOCK=1 on a MaxBurst-limit transfer, SHALL keep the grant and wrap BEAT_CNT to 0; release on REQ[SEL]=0 still applies.
REQ-026 Without PAM_ARB_LOCK_EN, SHALL omit the LOCK port, and the burst limit SHALL always release.

Verification (Depth=4, MaxBurst=4)
REQ-027 Reset, then REQ=0010 held and READY_IN=1 -> GNT=0010 and SEL=1 next cycle; 4 beats; release; 1 IDLE cycle; regrant to index 1.
REQ-028 REQ=1111 held and READY_IN=1 -> grant order 0,1,2,3,0 with 4 beats each, PTR wrapping 3 -> 0.
REQ-029 Grant on index 2; drop REQ[2] after 2 beats -> release, PTR=3, next grant index 3 if REQ[3]=1, else index 0.
REQ-030 Grant on index 0; READY_IN=0 for 5 cycles -> BEAT_CNT stays 0, GNT holds 0001, BUSY=1.
REQ-031 RST pulse mid-burst on index 2 after 1 beat -> all outputs zero immediately; REQ=0100 afterwards -> fresh 4-beat burst.
REQ-032 With PAM_ARB_LOCK_EN defined, LOCK=1 and REQ[1] held -> grant on index 1 persists past 8 beats; LOCK=0 -> release after the next burst-limit transfer.
